// File: rtl/bnn_cmd_sequencer.sv
// Command sequencer between the UART byte interface and the BNN inference core.
// Decodes command bytes, streams the image into the core buffer and queues one response per command.
module bnn_cmd_sequencer #(
    parameter int unsigned IMG_BYTES      = 8,
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000,
    parameter int unsigned ADDR_W         = $clog2(IMG_BYTES)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic [7:0]        tx_data,
    output logic              tx_start,
    input  logic              tx_busy,
    output logic              img_wr_en,
    output logic [ADDR_W-1:0] img_wr_addr,
    output logic [7:0]        img_wr_data,
    output logic              core_start,
    input  logic              core_done,
    input  logic [3:0]        core_result,
    output logic              busy
);

    localparam int unsigned TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMG_BYTES - 1);

    localparam logic [7:0] CMD_LOAD   = 8'h01;
    localparam logic [7:0] CMD_RUN    = 8'h02;
    localparam logic [7:0] CMD_STATUS = 8'h03;
    localparam logic [7:0] RSP_ACK    = 8'hA5;
    localparam logic [7:0] RSP_NAK    = 8'hEE;

    typedef enum logic [1:0] {StIdle, StLoad, StRun, StSend} state_e;

    state_e state_q, state_d;

    logic [ADDR_W-1:0] cnt_q;
    logic [TO_W-1:0]   to_q;
    logic              img_loaded_q;
    logic              result_valid_q;
    logic              overrun_q;
    logic [3:0]        last_result_q;
    logic [7:0]        tx_data_q;
    logic              img_wr_en_q;
    logic [ADDR_W-1:0] img_wr_addr_q;
    logic [7:0]        img_wr_data_q;
    logic              core_start_q;

    logic last_byte;
    logic timeout_hit;

    assign last_byte   = (cnt_q == LAST_ADDR);
    assign timeout_hit = (to_q == TO_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (rx_valid) begin
                    if (rx_data == CMD_LOAD) begin
                        state_d = StLoad;
                    end else if (rx_data == CMD_RUN && img_loaded_q) begin
                        state_d = StRun;
                    end else begin
                        state_d = StSend;
                    end
                end
            end
            StLoad: begin
                if (rx_valid) begin
                    if (last_byte) state_d = StSend;
                end else if (timeout_hit) begin
                    state_d = StSend;
                end
            end
            StRun: begin
                if (core_done || timeout_hit) state_d = StSend;
            end
            StSend: begin
                if (!tx_busy) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        rx_ready = 1'b0;
        busy     = 1'b0;
        tx_start = 1'b0;
        case (state_q)
            StIdle, StLoad: rx_ready = 1'b1;
            StRun:          busy     = 1'b1;
            StSend: begin
                busy     = 1'b1;
                tx_start = !tx_busy;
            end
            default: ;
        endcase
    end

    // Datapath: strobes default low each cycle; everything else holds unless updated.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q          <= '0;
            to_q           <= '0;
            img_loaded_q   <= 1'b0;
            result_valid_q <= 1'b0;
            overrun_q      <= 1'b0;
            last_result_q  <= 4'h0;
            tx_data_q      <= 8'h00;
            img_wr_en_q    <= 1'b0;
            img_wr_addr_q  <= '0;
            img_wr_data_q  <= 8'h00;
            core_start_q   <= 1'b0;
        end else begin
            img_wr_en_q  <= 1'b0;
            core_start_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (rx_valid) begin
                        cnt_q <= '0;
                        to_q  <= '0;
                        if (rx_data == CMD_LOAD) begin
                            img_loaded_q <= 1'b0;
                        end else if (rx_data == CMD_RUN && img_loaded_q) begin
                            core_start_q   <= 1'b1;
                            result_valid_q <= 1'b0;
                        end else if (rx_data == CMD_STATUS) begin
                            tx_data_q <= {img_loaded_q, result_valid_q, overrun_q, 1'b0,
                                          last_result_q};
                            overrun_q <= 1'b0;
                        end else begin
                            tx_data_q <= RSP_NAK;
                        end
                    end
                end
                StLoad: begin
                    if (rx_valid) begin
                        img_wr_en_q   <= 1'b1;
                        img_wr_addr_q <= cnt_q;
                        img_wr_data_q <= rx_data;
                        to_q          <= '0;
                        if (last_byte) begin
                            img_loaded_q <= 1'b1;
                            tx_data_q    <= RSP_ACK;
                        end else begin
                            cnt_q <= cnt_q + ADDR_W'(1);
                        end
                    end else if (timeout_hit) begin
                        tx_data_q <= RSP_NAK;
                    end else begin
                        to_q <= to_q + TO_W'(1);
                    end
                end
                StRun: begin
                    if (core_done) begin
                        last_result_q  <= core_result;
                        result_valid_q <= 1'b1;
                        tx_data_q      <= {4'h0, core_result};
                    end else if (timeout_hit) begin
                        tx_data_q <= RSP_NAK;
                    end else begin
                        to_q <= to_q + TO_W'(1);
                    end
                end
                default: ;
            endcase
            // Bytes arriving while CTS is low are discarded but remembered.
            if (rx_valid && (state_q == StRun || state_q == StSend)) begin
                overrun_q <= 1'b1;
            end
        end
    end

    assign tx_data     = tx_data_q;
    assign img_wr_en   = img_wr_en_q;
    assign img_wr_addr = img_wr_addr_q;
    assign img_wr_data = img_wr_data_q;
    assign core_start  = core_start_q;

endmodule

// File: tb/tb_bnn_cmd_sequencer.sv
// Bench for bnn_cmd_sequencer: transaction-level model feeding scoreboards checked every cycle,
// plus directed sequences with hand-computed response bytes.
module tb_bnn_cmd_sequencer;

    localparam int unsigned IMG_BYTES      = 8;
    localparam int unsigned TIMEOUT_CYCLES = 16;
    localparam int unsigned ADDR_W         = 3;

    logic              clk = 1'b0;
    logic              rst;
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic [7:0]        tx_data;
    logic              tx_start;
    logic              tx_busy;
    logic              img_wr_en;
    logic [ADDR_W-1:0] img_wr_addr;
    logic [7:0]        img_wr_data;
    logic              core_start;
    logic              core_done;
    logic [3:0]        core_result;
    logic              busy;

    bnn_cmd_sequencer #(
        .IMG_BYTES      (IMG_BYTES),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .ADDR_W         (ADDR_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .tx_data     (tx_data),
        .tx_start    (tx_start),
        .tx_busy     (tx_busy),
        .img_wr_en   (img_wr_en),
        .img_wr_addr (img_wr_addr),
        .img_wr_data (img_wr_data),
        .core_start  (core_start),
        .core_done   (core_done),
        .core_result (core_result),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    // Model of the host-visible state, updated per transaction.
    bit         m_loaded, m_rv, m_ovr;
    logic [3:0] m_last;
    logic [7:0] exp_tx[$];
    logic [10:0] exp_wr[$];
    int         exp_starts;

    bit         mon_en = 1'b0;
    int         tx_count = 0;
    logic [7:0] tx_last = 8'h00;

    task automatic chk(input bit ok, input string name, input int act, input int exp);
        n_total++;
        if (ok) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            chk(rx_ready == !busy, "ready_vs_busy", int'(rx_ready), int'(!busy));
            if (tx_start) begin
                chk(!tx_busy, "tx_start_while_busy", int'(tx_busy), 0);
                if (exp_tx.size() == 0) begin
                    chk(1'b0, "tx_unexpected", int'(tx_data), -1);
                end else begin
                    logic [7:0] e;
                    e = exp_tx.pop_front();
                    chk(tx_data == e, "tx_byte_model", int'(tx_data), int'(e));
                end
                tx_count++;
                tx_last = tx_data;
            end
            if (img_wr_en) begin
                if (exp_wr.size() == 0) begin
                    chk(1'b0, "wr_unexpected", int'({img_wr_addr, img_wr_data}), -1);
                end else begin
                    logic [10:0] w;
                    w = exp_wr.pop_front();
                    chk({img_wr_addr, img_wr_data} == w, "img_write_model",
                        int'({img_wr_addr, img_wr_data}), int'(w));
                end
            end
            if (core_start) begin
                chk(exp_starts > 0, "core_start_expected", 1, exp_starts);
                if (exp_starts > 0) exp_starts--;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic command(input logic [7:0] b);
        case (b)
            8'h01: m_loaded = 1'b0;
            8'h02: begin
                if (m_loaded) begin
                    exp_starts++;
                    m_rv = 1'b0;
                end else begin
                    exp_tx.push_back(8'hEE);
                end
            end
            8'h03: begin
                exp_tx.push_back({m_loaded, m_rv, m_ovr, 1'b0, m_last});
                m_ovr = 1'b0;
            end
            default: exp_tx.push_back(8'hEE);
        endcase
        send(b);
    endtask

    task automatic payload(input logic [7:0] b, input int idx);
        exp_wr.push_back({3'(idx), b});
        if (idx == IMG_BYTES - 1) begin
            exp_tx.push_back(8'hA5);
            m_loaded = 1'b1;
        end
        send(b);
        chk(img_wr_en == 1'b1, "wr_latency", int'(img_wr_en), 1);
    endtask

    task automatic finish_run(input logic [3:0] r);
        m_last = r;
        m_rv   = 1'b1;
        exp_tx.push_back({4'h0, r});
        core_done   = 1'b1;
        core_result = r;
        tick();
        core_done   = 1'b0;
        core_result = 4'h0;
    endtask

    task automatic wait_tx(input int n0, input logic [7:0] lit, input string name);
        int k = 0;
        while (tx_count == n0 && k < 60) begin
            @(negedge clk);
            #1;
            k++;
        end
        chk(tx_count != n0, {name, "_seen"}, tx_count, n0 + 1);
        if (tx_count != n0) chk(tx_last == lit, name, int'(tx_last), int'(lit));
        tick();
    endtask

    task automatic check_reset_outputs(input string name);
        chk(rx_ready == 1'b1, {name, "_rx_ready"}, int'(rx_ready), 1);
        chk(tx_start == 1'b0, {name, "_tx_start"}, int'(tx_start), 0);
        chk(tx_data == 8'h00, {name, "_tx_data"}, int'(tx_data), 0);
        chk(img_wr_en == 1'b0, {name, "_wr_en"}, int'(img_wr_en), 0);
        chk({img_wr_addr, img_wr_data} == 11'h0, {name, "_wr_bus"},
            int'({img_wr_addr, img_wr_data}), 0);
        chk(core_start == 1'b0, {name, "_core_start"}, int'(core_start), 0);
        chk(busy == 1'b0, {name, "_busy"}, int'(busy), 0);
    endtask

    task automatic model_reset();
        m_loaded   = 1'b0;
        m_rv       = 1'b0;
        m_ovr      = 1'b0;
        m_last     = 4'h0;
        exp_starts = 0;
        exp_tx.delete();
        exp_wr.delete();
    endtask

    initial begin
        int n0;
        rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; tx_busy = 1'b0;
        core_done = 1'b0; core_result = 4'h0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check_reset_outputs("reset");
        mon_en = 1'b1;

        // Status straight after reset.
        n0 = tx_count; command(8'h03); wait_tx(n0, 8'h00, "status_after_reset");

        // Early start and unknown command.
        n0 = tx_count; command(8'h02); wait_tx(n0, 8'hEE, "early_start_nak");
        n0 = tx_count; command(8'h55); wait_tx(n0, 8'hEE, "unknown_nak");

        // Full back-to-back load, then inference finishing on the timeout edge.
        command(8'h01);
        n0 = tx_count;
        for (int i = 0; i < IMG_BYTES; i++) payload(8'h10 + 8'(i), i);
        chk(tx_start && tx_data == 8'hA5, "ack_same_cycle", int'(tx_data), 8'hA5);
        wait_tx(n0, 8'hA5, "load_ack");
        command(8'h02);
        chk(core_start == 1'b1, "core_start_latency", int'(core_start), 1);
        tick();
        chk(core_start == 1'b0, "core_start_width", int'(core_start), 0);
        repeat (14) tick();
        n0 = tx_count;
        finish_run(4'h7);
        chk(tx_start && tx_data == 8'h07, "done_beats_timeout", int'(tx_data), 8'h07);
        wait_tx(n0, 8'h07, "result_byte");
        n0 = tx_count; command(8'h03); wait_tx(n0, 8'hC7, "status_after_run");

        // Overrun during RUN, then backpressure on the result.
        command(8'h02);
        m_ovr = 1'b1;
        send(8'h99);
        tx_busy = 1'b1;
        n0 = tx_count;
        finish_run(4'h3);
        for (int i = 0; i < 10; i++) begin
            chk(!tx_start && tx_data == 8'h03 && busy, "hold_while_busy",
                int'({tx_start, tx_data}), 8'h03);
            tick();
        end
        tx_busy = 1'b0;
        #1;
        chk(tx_start == 1'b1, "start_after_busy_falls", int'(tx_start), 1);
        wait_tx(n0, 8'h03, "backpressured_result");
        n0 = tx_count; command(8'h03); wait_tx(n0, 8'hE3, "status_overrun");

        // Inference timeout.
        command(8'h02);
        repeat (15) tick();
        chk(busy && !tx_start, "run_timeout_not_early", int'(tx_start), 0);
        n0 = tx_count;
        exp_tx.push_back(8'hEE);
        tick();
        wait_tx(n0, 8'hEE, "run_timeout_nak");
        n0 = tx_count; command(8'h03); wait_tx(n0, 8'h83, "status_after_run_timeout");

        // Load timeout after three payload bytes.
        command(8'h01);
        for (int i = 0; i < 3; i++) payload(8'hB0 + 8'(i), i);
        repeat (15) tick();
        chk(rx_ready && !busy, "load_timeout_not_early", int'(busy), 0);
        n0 = tx_count;
        exp_tx.push_back(8'hEE);
        tick();
        wait_tx(n0, 8'hEE, "load_timeout_nak");
        n0 = tx_count; command(8'h02); wait_tx(n0, 8'hEE, "run_after_load_timeout");

        // Reset mid-LOAD; payload command codes are stored, not decoded.
        command(8'h01);
        for (int i = 0; i < 4; i++) payload(8'h01 + 8'(i), i);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_reset_outputs("reset_mid_load");
        model_reset();
        n0 = tx_count; command(8'h02); wait_tx(n0, 8'hEE, "run_after_reset");
        n0 = tx_count; command(8'h03); wait_tx(n0, 8'h00, "status_after_mid_reset");

        repeat (3) tick();
        chk(exp_tx.size() == 0, "tx_queue_drained", exp_tx.size(), 0);
        chk(exp_wr.size() == 0, "wr_queue_drained", exp_wr.size(), 0);
        chk(exp_starts == 0, "starts_drained", exp_starts, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
